// File: rtl/qif_isi_encoder.sv
// qif_isi_encoder: detects rising edges on the neuron spike line and queues inter-spike intervals in a FWFT FIFO.
// Build option QIF_ISI_REFRACT_EN drops spikes that arrive fewer than REFRACT cycles after the last accepted one.
//
// state | meaning
// IDLE  | no reference spike yet; the first accepted edge only starts the interval
// COUNT | counting cycles since the last accepted edge; each new edge yields an ISI
module qif_isi_encoder #(
  parameter int ISI_W   = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int REFRACT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             clr,
  output logic [ISI_W-1:0] out_isi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] spike_count,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_ONE  = ISI_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      FILL_ONE = (AW+1)'(1);
  localparam logic [AW:0]      FILL_MAX = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REFRACT < 0) begin : g_bad_param
    $error("qif_isi_encoder: DEPTH must be a power of two >= 2 and REFRACT >= 0");
  end

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nxt;
  logic             spike_d;
  logic [ISI_W-1:0] isi_cnt, isi_cnt_nxt;
  logic [ISI_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fill;
  logic             spike_evt, too_soon, accept, push, pop, full, wr_en, drop_set;

  assign spike_evt = spike_in & ~spike_d;
  assign full      = (fill == FILL_MAX);
  assign out_valid = (fill != '0);
  assign out_isi   = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid & out_ready & ~clr;
  // A full FIFO still takes the new ISI when the head leaves in the same cycle.
  assign wr_en     = push & (~full | pop);
  assign drop_set  = push & full & ~pop;

`ifdef QIF_ISI_REFRACT_EN
  localparam logic [ISI_W-1:0] REFRACT_V = ISI_W'(REFRACT);
  assign too_soon = (isi_cnt < REFRACT_V);
`else
  assign too_soon = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      isi_cnt <= '0;
    end else begin
      state   <= state_nxt;
      isi_cnt <= isi_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    isi_cnt_nxt = isi_cnt;
    accept      = 1'b0;
    push        = 1'b0;
    if (clr) begin
      state_nxt   = IDLE;
      isi_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (spike_evt) begin
            accept      = 1'b1;
            isi_cnt_nxt = ISI_ONE;
            state_nxt   = COUNT;
          end
        end
        COUNT: begin
          if (spike_evt && !too_soon) begin
            accept      = 1'b1;
            push        = 1'b1;
            isi_cnt_nxt = ISI_ONE;
          end else if (isi_cnt != ISI_MAX) begin
            isi_cnt_nxt = isi_cnt + ISI_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // History keeps sampling through clr so a line held high across it is not a new edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) spike_d <= 1'b0;
    else      spike_d <= spike_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= isi_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_count <= '0;
      drop        <= 1'b0;
    end else if (clr) begin
      spike_count <= '0;
      drop        <= 1'b0;
    end else begin
      if (accept && spike_count != CNT_MAX) spike_count <= spike_count + CNT_ONE;
      if (drop_set) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qif_isi_encoder.sv
// tb_qif_isi_encoder: directed and randomized checks of qif_isi_encoder against a cycle-time reference model.
// Honors QIF_ISI_REFRACT_EN to select refractory expectations.
module tb_qif_isi_encoder;
  localparam int ISI_W   = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int ISI_MAX = 255;
  localparam int CNT_MAX = 65535;
`ifdef QIF_ISI_REFRACT_EN
  localparam int REFRACT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             spike_in = 1'b0;
  logic             clr = 1'b0;
  logic             out_ready = 1'b0;
  logic [ISI_W-1:0] out_isi;
  logic             out_valid;
  logic [CNT_W-1:0] spike_count;
  logic             drop;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edge times in absolute cycles, ISI = time difference.
  int     m_q[$];
  int     m_cnt;
  bit     m_drop;
  bit     m_prev;
  longint m_cyc;
  longint m_last;

  qif_isi_encoder dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .clr(clr),
    .out_isi(out_isi), .out_valid(out_valid), .out_ready(out_ready),
    .spike_count(spike_count), .drop(drop)
  );

  always #5 clk = ~clk;

  function automatic bit too_soon(input longint isi);
`ifdef QIF_ISI_REFRACT_EN
    return isi < REFRACT;
`else
    return isi < 0;
`endif
  endfunction

  function automatic int exp_isi();
    return (m_q.size() > 0) ? m_q[0] : 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cnt  = 0;
    m_drop = 0;
    m_prev = 0;
    m_cyc  = 0;
    m_last = -1;
  endtask

  task automatic step(input logic s, input logic r, input logic c);
    bit     ev;
    bit     pop;
    longint isi;
    spike_in  = s;
    out_ready = r;
    clr       = c;
    @(posedge clk);
    m_cyc++;
    ev     = s && !m_prev;
    m_prev = s;
    if (c) begin
      m_q.delete();
      m_cnt  = 0;
      m_drop = 0;
      m_last = -1;
    end else begin
      pop = (m_q.size() > 0) && r;
      if (pop) void'(m_q.pop_front());
      if (ev) begin
        if (m_last < 0) begin
          m_last = m_cyc;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
          isi = m_cyc - m_last;
          if (isi > ISI_MAX) isi = ISI_MAX;
          if (!too_soon(isi)) begin
            m_last = m_cyc;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_q.size() < DEPTH) m_q.push_back(int'(isi));
            else m_drop = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      spike_in  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || spike_count !== '0 || drop !== 1'b0 || out_isi !== '0) begin
        n_err++;
        $display("FAIL reset_hold: valid=%b count=%0d drop=%b isi=%0d expected 0 0 0 0",
                 out_valid, spike_count, drop, out_isi);
      end
    end
    spike_in  = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0 || spike_count !== '0 || drop !== 1'b0 || out_isi !== '0) begin
        n_err++;
        $display("FAIL idle_quiet: valid=%b count=%0d drop=%b isi=%0d expected 0 0 0 0",
                 out_valid, spike_count, drop, out_isi);
      end
    end
  endtask

  task automatic test_basic();
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || spike_count !== 16'd1) begin
      n_err++;
      $display("FAIL basic_first: valid=%b count=%0d expected 0 1", out_valid, spike_count);
    end
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd7) begin
      n_err++;
      $display("FAIL basic_isi7: valid=%b isi=%0d expected 1 7", out_valid, out_isi);
    end
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pop: valid=%b expected 0", out_valid);
    end
    repeat (18) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd20) begin
      n_err++;
      $display("FAIL basic_isi20: valid=%b isi=%0d expected 1 20", out_valid, out_isi);
    end
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (spike_count !== 16'd3) begin
      n_err++;
      $display("FAIL basic_count: got %0d expected 3", spike_count);
    end
  endtask

  task automatic test_saturation();
    int g;
    step(1'b1, 1'b1, 1'b0);
    repeat (299) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd255) begin
      n_err++;
      $display("FAIL sat_300: valid=%b isi=%0d expected 1 255", out_valid, out_isi);
    end
    repeat (254) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd255) begin
      n_err++;
      $display("FAIL sat_255: valid=%b isi=%0d expected 1 255", out_valid, out_isi);
    end
    g = $urandom_range(3, 254);
    repeat (g - 1) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== ISI_W'(g)) begin
      n_err++;
      $display("FAIL sat_rand_gap: valid=%b isi=%0d expected 1 %0d", out_valid, out_isi, g);
    end
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_fifo_full();
    step(1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 6; e++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd4 || drop !== 1'b1 || spike_count !== 16'd6) begin
      n_err++;
      $display("FAIL full_state: valid=%b isi=%0d drop=%b count=%0d expected 1 4 1 6",
               out_valid, out_isi, drop, spike_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_isi !== 8'd4) begin
        n_err++;
        $display("FAIL full_drain%0d: valid=%b isi=%0d expected 1 4", i, out_valid, out_isi);
      end
      step(1'b0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || drop !== 1'b1) begin
      n_err++;
      $display("FAIL full_empty: valid=%b drop=%b expected 0 1", out_valid, drop);
    end
    step(1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 5; e++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (drop !== 1'b0 || out_valid !== 1'b1 || out_isi !== 8'd4) begin
      n_err++;
      $display("FAIL full_pushpop: drop=%b valid=%b isi=%0d expected 0 1 4", drop, out_valid, out_isi);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || drop !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop_drain: valid=%b drop=%b expected 0 0", out_valid, drop);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd3) begin
      n_err++;
      $display("FAIL one_pushpop: valid=%b isi=%0d expected 1 3", out_valid, out_isi);
    end
  endtask

  task automatic test_clr();
    for (int e = 0; e < 6; e++) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || drop !== 1'b1) begin
      n_err++;
      $display("FAIL clr_pre: valid=%b drop=%b expected 1 1", out_valid, drop);
    end
    step(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || spike_count !== '0 || drop !== 1'b0 || out_isi !== '0) begin
      n_err++;
      $display("FAIL clr_flush: valid=%b count=%0d drop=%b isi=%0d expected 0 0 0 0",
               out_valid, spike_count, drop, out_isi);
    end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (spike_count !== '0) begin
      n_err++;
      $display("FAIL clr_held_high: count=%0d expected 0", spike_count);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd9 || spike_count !== 16'd2) begin
      n_err++;
      $display("FAIL clr_isi9: valid=%b isi=%0d count=%0d expected 1 9 2",
               out_valid, out_isi, spike_count);
    end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clr_single: valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_refract();
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
`ifdef QIF_ISI_REFRACT_EN
    n_cmp++;
    if (out_valid !== 1'b0 || spike_count !== 16'd1) begin
      n_err++;
      $display("FAIL refract_ignore: valid=%b count=%0d expected 0 1", out_valid, spike_count);
    end
`else
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd2 || spike_count !== 16'd2) begin
      n_err++;
      $display("FAIL refract_off_isi2: valid=%b isi=%0d count=%0d expected 1 2 2",
               out_valid, out_isi, spike_count);
    end
`endif
    repeat (7) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
`ifdef QIF_ISI_REFRACT_EN
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd10 || spike_count !== 16'd2) begin
      n_err++;
      $display("FAIL refract_isi10: valid=%b isi=%0d count=%0d expected 1 10 2",
               out_valid, out_isi, spike_count);
    end
`else
    n_cmp++;
    if (out_valid !== 1'b1 || out_isi !== 8'd8 || spike_count !== 16'd3) begin
      n_err++;
      $display("FAIL refract_off_isi8: valid=%b isi=%0d count=%0d expected 1 8 3",
               out_valid, out_isi, spike_count);
    end
`endif
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic s;
    logic r;
    logic c;
    int   rp;
    s  = 1'b0;
    rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rp = $urandom_range(0, 100);
      if ($urandom_range(0, 3) == 0) s = ~s;
      r = 1'($urandom_range(0, 99) < rp);
      c = 1'($urandom_range(0, 499) == 0);
      step(s, r, c);
      n_cmp++;
      if (out_valid !== (m_q.size() > 0)) begin
        n_err++;
        $display("FAIL rand_valid@%0d: got %b expected %b", i, out_valid, m_q.size() > 0);
      end
      n_cmp++;
      if (out_isi !== ISI_W'(exp_isi())) begin
        n_err++;
        $display("FAIL rand_isi@%0d: got %0d expected %0d", i, out_isi, exp_isi());
      end
      n_cmp++;
      if (spike_count !== CNT_W'(m_cnt)) begin
        n_err++;
        $display("FAIL rand_count@%0d: got %0d expected %0d", i, spike_count, m_cnt);
      end
      n_cmp++;
      if (drop !== m_drop) begin
        n_err++;
        $display("FAIL rand_drop@%0d: got %b expected %b", i, drop, m_drop);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_fifo_full();
    test_clr();
    test_refract();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qif_isi_encoder.md
Name: qif_isi_encoder

Overview:
- Downstream consumer of the QIF neuron's spike output.
- Detects rising edges on the 1-bit spike line.
- Measures the inter-spike interval (ISI) in clock cycles and queues each ISI in a small FIFO, drained by a valid/ready handshake toward readout/IO logic.
- Also keeps a saturating total spike count and a sticky drop flag for host observation.

Parameters:
- ISI_W, 8, width of ISI counter and FIFO entries; ISI saturates at 2^ISI_W-1.
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, 16, width of total spike counter; saturating.
- REFRACT, 3, minimum accepted ISI in cycles; used only when REFRACT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets); released synchronously by upstream logic.
- spike_in  in  1  spike line from neuron; may stay high for several cycles, only rising edges count.
- clr  in  1  synchronous clear: flush FIFO, zero counters, clear drop flag, state->IDLE.
- out_isi  out  ISI_W  FIFO head ISI value; valid only while out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid&out_ready at a clock edge.
- spike_count  out  CNT_W  total accepted spikes since reset/clr, saturating at all-ones.
- drop  out  1  sticky: set when an ISI was discarded because the FIFO was full.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, spike_d=0, isi_cnt=0, FIFO empty (wr/rd ptr=0, count=0).
  - out_valid=0, out_isi=0, spike_count=0, drop=0.
- Edge detect: spike_d <= spike_in every cycle; event = spike_in & ~spike_d (combinational from registered history).
- State machine:
  - IDLE: no reference spike yet. On event: spike_count++, isi_cnt<=1, ->COUNT. Nothing is pushed; the first spike gives no ISI.
  - COUNT, no event: isi_cnt <= min(isi_cnt+1, 2^ISI_W-1).
  - COUNT, event: push isi_cnt, spike_count++, isi_cnt<=1, stay in COUNT.
  - Resulting ISI = cycle distance between the two sampled rising edges (edges at edges 10 and 17 -> ISI 7). Saturated value is pushed as-is.
- FIFO:
  - Push at the edge sampling the event; out_valid rises after that same edge (1-cycle latency from sampled edge to visible output).
  - out_isi = head entry, first-word-fall-through; 0 when empty.
  - Pop when out_valid&out_ready. out_ready while empty is ignored.
  - Push when full and no pop: entry discarded, drop<=1; spike_count still increments and isi_cnt still restarts.
  - Push and pop in the same cycle when full: both succeed, count unchanged, drop unaffected.
  - Push and pop when count=1: both succeed, out_valid stays 1, head becomes the new entry.
  - Pointers wrap modulo DEPTH.
- spike_count saturates at 2^CNT_W-1; events are still processed.
- clr=1: takes priority over event/push/pop that cycle. Result identical to reset except spike_d still samples spike_in, so a line held high across clr gives no event.
- drop is cleared only by rst or clr.

Optional Feature:
- Macro: QIF_ISI_REFRACT_EN.
- Defined: in COUNT, an event with isi_cnt < REFRACT is ignored entirely: no push, no spike_count increment, isi_cnt keeps counting. Events in IDLE are always accepted.
- Undefined: all events are accepted; REFRACT is unused and no comparator logic is generated.

Test Plan:
- Reset/idle: rst=0 with spike_in toggling -> out_valid=0, spike_count=0, drop=0; release, no spikes for 50 cycles -> outputs unchanged.
- Basic ISI: rising edges at sampled cycles 5, 12, 32, spike high 2 cycles each, out_ready=1 -> out_isi 7 then 20, each valid 1 cycle after its edge; spike_count=3.
- Saturation: ISI_W=8, edges 300 cycles apart -> out_isi=255.
- FIFO full: out_ready=0, 6 edges spaced 4 cycles -> 4 entries all =4, drop=1, spike_count=6. Then out_ready=1 -> four pops of 4, out_valid falls. Push+pop at full in the same cycle -> no drop.
- clr mid-operation: 2 entries queued, drop=1, clr pulse alongside an event -> FIFO empty, spike_count=0, drop=0, state IDLE; next two edges 9 apart -> single out_isi=9.
- With QIF_ISI_REFRACT_EN, REFRACT=3: edges at 10, 12, 20 -> edge 12 ignored; out_isi=10 (20-10); spike_count=2. Without the macro -> out_isi 2 then 8; spike_count=3.
